// File: rtl/ysyx_22040038_pkg.sv
// Shared types and constants for the ysyx_22040038 writeback path.
package ysyx_22040038_pkg;

  // Default geometry of the writeback path.
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 64;

  // Arbiter grant encoding.
  typedef logic [1:0] grant_t;
  localparam grant_t GNT_NONE = 2'd0;
  localparam grant_t GNT_ALU  = 2'd1;
  localparam grant_t GNT_LSU  = 2'd2;

  // A completed result on its way to the regfile write port.
  typedef struct packed {
    logic                     valid;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/ysyx_22040038_wb_ctrl_if.sv
// Result handshakes from the ALU and LSU into the writeback controller.
// master: the execution units; slave: the writeback controller.
interface ysyx_22040038_wb_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic [DATA_WIDTH-1:0] lsu_data;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    input  alu_ready, lsu_ready
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    output alu_ready, lsu_ready
  );
endinterface

// File: rtl/ysyx_22040038_wb_arb.sv
// Two-source writeback arbiter. LSU wins by default; an ALU result that has
// lost STALL_LIMIT consecutive cycles takes the next contended cycle.
module ysyx_22040038_wb_arb
  import ysyx_22040038_pkg::*;
#(
  parameter int STALL_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   alu_valid,
  input  logic   lsu_valid,
  output logic   alu_ready,
  output logic   lsu_ready,
  output grant_t grant
);

  logic [3:0] stall_q;
  logic       alu_prio;

  assign alu_prio = (stall_q == 4'(STALL_LIMIT));

  // Grant selection: readies depend only on valids and the counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = GNT_NONE;
    if (alu_valid && (!lsu_valid || alu_prio)) grant = GNT_ALU;
    else if (lsu_valid)                        grant = GNT_LSU;
  end

  assign alu_ready = (grant == GNT_ALU);
  assign lsu_ready = (grant == GNT_LSU);

  // Starvation counter: counts ALU-lost cycles, saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)                       stall_q <= '0;
    else if (!alu_valid || alu_ready) stall_q <= '0;
    else if (!alu_prio)               stall_q <= stall_q + 4'd1;
  end

endmodule

// File: rtl/ysyx_22040038_wb_ctrl.sv
// Writeback controller: arbitrates ALU/LSU results onto the registered
// regfile write port, keeps a per-register busy scoreboard and answers
// decode-stage hazard queries.
// Optional feature macro: YSYX_22040038_WB_BYPASS_EN forwards the value on
// the write port to decode in the same cycle it is written.
module ysyx_22040038_wb_ctrl
  import ysyx_22040038_pkg::*;
#(
  parameter int ADDR_WIDTH  = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = WB_DATA_WIDTH,
  parameter int STALL_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ysyx_22040038_wb_ctrl_if.slave bus,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] raaddr,
  input  logic [ADDR_WIDTH-1:0] rbaddr,
  output logic                  ra_busy,
  output logic                  rb_busy,
  output logic                  ra_fwd_valid,
  output logic                  rb_fwd_valid,
  output logic [DATA_WIDTH-1:0] ra_fwd_data,
  output logic [DATA_WIDTH-1:0] rb_fwd_data,
  output logic                  err
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  grant_t           grant;
  wb_req_t          req;
  wb_req_t          rf_q;
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             waw;
  logic             hs_bad;

  ysyx_22040038_wb_arb #(.STALL_LIMIT(STALL_LIMIT)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (bus.alu_valid),
    .lsu_valid (bus.lsu_valid),
    .alu_ready (bus.alu_ready),
    .lsu_ready (bus.lsu_ready),
    .grant     (grant)
  );

  // Winning result of this cycle's handshake (valid=0 when no handshake).
  always_comb begin
    req = '0;
    unique case (grant)
      GNT_ALU: begin
        req.valid = 1'b1;
        req.addr  = bus.alu_addr;
        req.data  = bus.alu_data;
      end
      GNT_LSU: begin
        req.valid = 1'b1;
        req.addr  = bus.lsu_addr;
        req.data  = bus.lsu_data;
      end
      default: ;
    endcase
  end

  // Output register: x0 writes complete the handshake but never assert wen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q <= '0;
    end else begin
      rf_q.valid <= req.valid && (req.addr != '0);
      if (req.valid) begin
        rf_q.addr <= req.addr;
        rf_q.data <= req.data;
      end
    end
  end

  assign rf_wen   = rf_q.valid;
  assign rf_waddr = rf_q.addr;
  assign rf_wdata = rf_q.data;

  // Scoreboard next state: clear on write, then set on issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_q.valid)                          busy_d[rf_q.addr]  = 1'b0;
    if (issue_valid && (issue_addr != '0))   busy_d[issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the busy vector is reset as a whole because stale busy bits after reset would stall decode forever.
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Protocol violations: WAW issue, or a result for a register nobody issued.
  assign waw    = issue_valid && (issue_addr != '0) && busy_q[issue_addr] &&
                  !(rf_q.valid && (rf_q.addr == issue_addr));
  assign hs_bad = req.valid && (req.addr != '0) && !busy_q[req.addr];

  // Sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err | waw | hs_bad;
  end

  // Hazard queries, optionally bypassing the value currently being written.
  always_comb begin
    ra_busy      = busy_q[raaddr];
    rb_busy      = busy_q[rbaddr];
    ra_fwd_valid = 1'b0;
    rb_fwd_valid = 1'b0;
    ra_fwd_data  = '0;
    rb_fwd_data  = '0;
`ifdef YSYX_22040038_WB_BYPASS_EN
    if (rf_q.valid && (rf_q.addr == raaddr) && (raaddr != '0)) begin
      ra_busy      = 1'b0;
      ra_fwd_valid = 1'b1;
      ra_fwd_data  = rf_q.data;
    end
    if (rf_q.valid && (rf_q.addr == rbaddr) && (rbaddr != '0)) begin
      rb_busy      = 1'b0;
      rb_fwd_valid = 1'b1;
      rb_fwd_data  = rf_q.data;
    end
`endif
  end

endmodule

// File: tb/tb_ysyx_22040038_wb_ctrl.sv
// Self-checking bench for ysyx_22040038_wb_ctrl: directed scenarios plus a
// randomized phase, all predicted by a behavioural model of the writeback
// rules. Expected regfile writes go into a scoreboard queue that a separate
// monitor drains whenever rf_wen is seen.
module tb_ysyx_22040038_wb_ctrl;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int SL = 4;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid;
  logic [AW-1:0] issue_addr;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] raaddr, rbaddr;
  logic          ra_busy, rb_busy, ra_fwd_valid, rb_fwd_valid;
  logic [DW-1:0] ra_fwd_data, rb_fwd_data;
  logic          err;

  always #5 clk = ~clk;

  ysyx_22040038_wb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ysyx_22040038_wb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STALL_LIMIT(SL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .issue_valid  (issue_valid),
    .issue_addr   (issue_addr),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .raaddr       (raaddr),
    .rbaddr       (rbaddr),
    .ra_busy      (ra_busy),
    .rb_busy      (rb_busy),
    .ra_fwd_valid (ra_fwd_valid),
    .rb_fwd_valid (rb_fwd_valid),
    .ra_fwd_data  (ra_fwd_data),
    .rb_fwd_data  (rb_fwd_data),
    .err          (err)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } res_t;
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; int due; } exp_t;

  // Model state: pending results per source, expected writes, register status.
  res_t          alu_q[$];
  res_t          lsu_q[$];
  exp_t          exp_q[$];
  bit            mbusy[NR];
  bit            m_err;
  bit            wbp;       // a write to the regfile happens this cycle
  logic [AW-1:0] wba;
  logic [DW-1:0] wbd;
  int            lost;      // consecutive cycles the ALU result has been refused

  // Stimulus knobs for the next cycle.
  logic          iss_v;
  logic [AW-1:0] iss_a, ra, rb;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every regfile write must match the oldest expected one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {59'd0, rf_waddr}, 64'hdead);
      end else begin
        e = exp_q.pop_front();
        check("wb_addr", 64'(rf_waddr), 64'(e.addr));
        check("wb_data", rf_wdata, e.data);
        check("wb_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One clock cycle: drive inputs, predict, check combinational outputs at the
  // negedge, then advance the model across the rising edge.
  task automatic run_cycle();
    bit   av, lv, aw, lw, waw, hsbad, ra_hit, rb_hit;
    res_t ah, lh, win;
    av = (alu_q.size() > 0);
    lv = (lsu_q.size() > 0);
    ah = av ? alu_q[0] : res_t'({AW'($urandom), rnd64()});
    lh = lv ? lsu_q[0] : res_t'({AW'($urandom), rnd64()});
    bus.alu_valid = av; bus.alu_addr = ah.addr; bus.alu_data = ah.data;
    bus.lsu_valid = lv; bus.lsu_addr = lh.addr; bus.lsu_data = lh.data;
    issue_valid = iss_v; issue_addr = iss_a;
    raaddr = ra; rbaddr = rb;

    // LSU first unless the ALU has already waited SL cycles.
    aw  = av && (!lv || lost >= SL);
    lw  = lv && !aw;
    win = aw ? ah : lh;
    if ((aw || lw) && win.addr != 0) exp_q.push_back('{win.addr, win.data, cyc + 1});

`ifdef YSYX_22040038_WB_BYPASS_EN
    ra_hit = wbp && wba == ra && ra != 0;
    rb_hit = wbp && wba == rb && rb != 0;
`else
    ra_hit = 1'b0;
    rb_hit = 1'b0;
`endif

    @(negedge clk);
    check("alu_ready", 64'(bus.alu_ready), 64'(aw));
    check("lsu_ready", 64'(bus.lsu_ready), 64'(lw));
    check("ra_busy", 64'(ra_busy), 64'(mbusy[ra] && !ra_hit));
    check("rb_busy", 64'(rb_busy), 64'(mbusy[rb] && !rb_hit));
    check("ra_fwd_valid", 64'(ra_fwd_valid), 64'(ra_hit));
    check("rb_fwd_valid", 64'(rb_fwd_valid), 64'(rb_hit));
    if (ra_hit) check("ra_fwd_data", ra_fwd_data, wbd);
    if (rb_hit) check("rb_fwd_data", rb_fwd_data, wbd);
`ifndef YSYX_22040038_WB_BYPASS_EN
    check("ra_fwd_data_zero", ra_fwd_data, 64'd0);
`endif
    check("err", 64'(err), 64'(m_err));

    @(posedge clk);
    waw   = iss_v && iss_a != 0 && mbusy[iss_a] && !(wbp && wba == iss_a);
    hsbad = (aw || lw) && win.addr != 0 && !mbusy[win.addr];
    m_err = m_err || waw || hsbad;
    if (wbp) mbusy[wba] = 1'b0;
    if (iss_v && iss_a != 0) mbusy[iss_a] = 1'b1;
    wbp = (aw || lw) && win.addr != 0;
    wba = win.addr;
    wbd = win.data;
    if (av && !aw) lost++;
    else           lost = 0;
    if (aw) void'(alu_q.pop_front());
    if (lw) void'(lsu_q.pop_front());
    #1;
  endtask

  // Reset (also used mid-operation): the in-flight write and all busy bits vanish.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_data = '0;
    issue_valid = 1'b0; issue_addr = '0;
    raaddr = ra; rbaddr = rb;
    alu_q.delete(); lsu_q.delete(); exp_q.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    m_err = 1'b0; wbp = 1'b0; lost = 0; iss_v = 1'b0;
    #1;
    check("rst_rf_wen", 64'(rf_wen), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", rf_wdata, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_ra_busy", 64'(ra_busy), 64'd0);
    check("rst_rb_busy", 64'(rb_busy), 64'd0);
    check("rst_fwd_valid", 64'(ra_fwd_valid | rb_fwd_valid), 64'd0);
    check("rst_fwd_data", ra_fwd_data | rb_fwd_data, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    iss_v = 1'b0;
    repeat (n) run_cycle();
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_v = 1'b1; iss_a = a;
    run_cycle();
    iss_v = 1'b0;
  endtask

  initial begin
    int guard;
    ra = '0; rb = '0; iss_v = 1'b0; iss_a = '0;
    do_reset();

    // Basic ALU writeback to x5 with a read hazard on x5.
    ra = 5; rb = 6;
    issue(5);
    idle(1);
    alu_q.push_back('{5'd5, 64'h1234});
    idle(3);

    // Simultaneous ALU/LSU results: LSU first, ALU next cycle.
    ra = 3; rb = 4;
    issue(3);
    issue(4);
    alu_q.push_back('{5'd3, 64'h3333});
    lsu_q.push_back('{5'd4, 64'h4444});
    idle(4);

    // Continuous LSU traffic starving the ALU.
    for (int i = 10; i < 16; i++) issue(AW'(i));
    issue(17);
    for (int i = 10; i < 16; i++) lsu_q.push_back('{AW'(i), 64'(i) * 64'h101});
    alu_q.push_back('{5'd17, 64'h1717});
    ra = 17; rb = 14;
    idle(10);

    // ALU write to x0: handshake completes, nothing is written.
    ra = 0; rb = 5;
    alu_q.push_back('{5'd0, 64'hFFFF});
    idle(3);

    // WAW on x7 sets a sticky error.
    ra = 7; rb = 0;
    issue(7);
    issue(7);
    idle(3);
    do_reset();

    // Re-issue of x7 in the cycle its write clears: legal, busy stays set.
    ra = 7; rb = 7;
    issue(7);
    alu_q.push_back('{5'd7, 64'h7777});
    idle(1);
    issue(7);
    idle(2);
    alu_q.push_back('{5'd7, 64'h7878});
    idle(3);

    // Forwarding window for x9.
    ra = 9; rb = 1;
    issue(9);
    alu_q.push_back('{5'd9, 64'hABCD});
    idle(4);

    // Reset while a write is in flight.
    ra = 8; rb = 8;
    issue(8);
    alu_q.push_back('{5'd8, 64'h8888});
    idle(1);
    do_reset();
    idle(2);

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      logic [AW-1:0] a;
      ra = AW'($urandom_range(0, NR - 1));
      rb = AW'($urandom_range(0, NR - 1));
      iss_v = 1'b0;
      a = AW'($urandom_range(1, NR - 1));
      if ($urandom_range(0, 99) < 50 && !mbusy[a]) begin
        iss_v = 1'b1;
        iss_a = a;
      end
      if ($urandom_range(0, 99) < 3) alu_q.push_back('{5'd0, rnd64()});
      run_cycle();
      if (iss_v) begin
        if ($urandom_range(0, 99) < 65) lsu_q.push_back('{iss_a, rnd64()});
        else                            alu_q.push_back('{iss_a, rnd64()});
      end
    end

    // Drain every outstanding result within a bounded number of cycles.
    iss_v = 1'b0;
    guard = 0;
    while ((alu_q.size() > 0 || lsu_q.size() > 0 || wbp) && guard < 200) begin
      run_cycle();
      guard++;
    end
    check("drain_timeout", 64'(guard < 200), 64'd1);
    idle(2);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22040038_wb_ctrl.md
# ysyx_22040038_wb_ctrl

Writeback controller and scoreboard that drives the register file's single write port. It arbitrates completed results from the ALU (single-cycle) and the LSU (multi-cycle) using valid/ready handshakes. It registers the winner onto the regfile write port and tracks a busy bit per architectural register. It also answers read-hazard queries for the two decode-stage read addresses.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width; the block tracks 2^ADDR_WIDTH registers.
- DATA_WIDTH, 64, result width.
- STALL_LIMIT, 4, consecutive ALU-lost cycles before ALU gets priority (range 1–15).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  dispatch issues an instruction with destination issue_addr.
- issue_addr  in  ADDR_WIDTH  destination register to mark busy.
- alu_valid / alu_ready  in / out  1  ALU result handshake.
- alu_addr, alu_data  in  ADDR_WIDTH, DATA_WIDTH  ALU result.
- lsu_valid / lsu_ready  in / out  1  LSU result handshake.
- lsu_addr, lsu_data  in  ADDR_WIDTH, DATA_WIDTH  LSU result.
- rf_wen, rf_waddr, rf_wdata  out  1, ADDR_WIDTH, DATA_WIDTH  registered regfile write port.
- raaddr, rbaddr  in  ADDR_WIDTH  decode read addresses.
- ra_busy, rb_busy  out  1  the operand is not yet valid in the regfile.
- ra_fwd_valid, rb_fwd_valid  out  1  forwarding hit (only meaningful with bypass).
- ra_fwd_data, rb_fwd_data  out  DATA_WIDTH  forwarded data.
- err  out  1  sticky protocol error.

## Operation
- At most one handshake per cycle. The ready outputs are combinational from the valid inputs. Sources must not make valid depend on ready.
- Default priority: LSU wins, so lsu_ready = lsu_valid.
- Starvation counter:
  - Counts cycles where alu_valid && !alu_ready; clears on an ALU handshake or when !alu_valid.
  - When the counter reaches STALL_LIMIT, the ALU wins the next contended cycle, and the counter clears.
- Handshake result: on a handshake, the output register loads {wen=(addr!=0), addr, data}. With no handshake, rf_wen returns to 0.
- Writes to x0 complete the handshake but never assert rf_wen.
- Scoreboard, busy[2^ADDR_WIDTH]:
  - Set: issue_valid && issue_addr!=0 sets busy[issue_addr].
  - Clear: busy[rf_waddr] clears at the edge where rf_wen=1.
  - Same address set and clear in the same cycle: set wins.
  - busy[0] is constant 0.
- err sets and holds until reset on either condition:
  - issue_valid to a register already busy and not being cleared that cycle (WAW; dispatch must prevent this).
  - A handshake whose address is not busy.
- ra_busy = busy[raaddr], subject to the bypass rule (Configuration). rb_busy is identical for rbaddr.

## Timing
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, all busy=0, starvation counter=0, err=0, fwd_valid=0, fwd_data=0.
- Handshake in cycle N gives rf_wen=1 in cycle N+1. The regfile is written and busy cleared at the end of cycle N+1.
- Without bypass, a read of that register sees ra_busy=0 and the new value in cycle N+2.
- Back-to-back handshakes give rf_wen=1 on consecutive cycles, for a throughput of 1/cycle.
- Reset mid-operation clears the in-flight output register; that write is lost and all busy bits clear.

## Configuration
- YSYX_22040038_WB_BYPASS_EN defined:
  - When rf_wen && rf_waddr==raaddr && raaddr!=0: ra_fwd_valid=1, ra_fwd_data=rf_wdata, and ra_busy=0 in cycle N+1. The same rule applies to rb.
  - Operand latency therefore drops by one cycle.
- Not defined: the fwd outputs are tied to 0, and ra_busy stays 1 through cycle N+1.

## Structure
- Shared package ysyx_22040038_pkg holds:
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - The wb_req_t struct {valid, addr, data}.
  - The grant encoding localparams GNT_NONE/GNT_ALU/GNT_LSU.
- One sub-module, ysyx_22040038_wb_arb: the two-source arbiter with its starvation counter, producing grant and readies. Scoreboard and output register stay in the top module.

## Test plan
- Reset, then issue x5; ALU returns x5=0x1234 in cycle 3 → rf_wen=1, waddr=5, wdata=0x1234 in cycle 4; ra_busy(x5) is 1 until cycle 4 and 0 from cycle 5; err=0.
- ALU and LSU both valid (x3, x4) → LSU granted first, ALU next cycle; rf_wen high two consecutive cycles.
- LSU valid continuously plus ALU valid, STALL_LIMIT=4 → ALU granted on the 5th contended cycle, then LSU resumes.
- ALU writes x0=0xFFFF → alu_ready=1, rf_wen stays 0, busy unaffected, err=0.
- Issue x7 twice with no writeback between → err=1 and held; a second issue in the same cycle as the x7 clear → err=0 and busy[x7]=1.
- With BYPASS_EN, in the rf_wen cycle for x9=0xABCD with raaddr=9 → ra_busy=0, ra_fwd_valid=1, ra_fwd_data=0xABCD; without the macro → ra_busy=1.
